q_loop_controller: RTL and testbench



---
 rtl/q_loop_pkg.sv | 33 +++
 rtl/q_measure.sv | 97 +++++++++
 rtl/q_loop_controller.sv | 104 ++++++++++
 tb/tb_q_loop_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/q_loop_pkg.sv
// Shared constants, the signed error type and saturating helpers for the Q-factor regulation loop.
package q_loop_pkg;

    localparam int unsigned BUS_WIDTH_DEF         = 10;
    localparam int unsigned WTD_BUS_WIDTH_DEF     = 3;
    localparam int unsigned Q_PER_PULSE_DEF       = 3;
    localparam int unsigned TOL_DEF               = 6;
    localparam int unsigned I_REF_DELTA_INSTB_DEF = 10;
    localparam int unsigned DELTA_Q_INSTB_DEF     = 50;
    localparam int unsigned INCLUDE_Q_DROP_DEF    = 1;

    // Error between desired and measured Q: one extra bit for the sign.
    typedef logic signed [BUS_WIDTH_DEF:0] q_err_t;

    function automatic int sat_add(input int a, input int b, input int max_val);
        int sum;
        int res;
        sum = a + b;
        if (sum < 0) begin
            res = 0;
        end else if (sum > max_val) begin
            res = max_val;
        end else begin
            res = sum;
        end
        return res;
    endfunction

    function automatic int sat_sub(input int a, input int b, input int max_val);
        return sat_add(a, -b, max_val);
    endfunction

endpackage

// File: rtl/q_measure.sv
// Q measurement front end: synchronizes the returned pulse train, accumulates pulses into a Q
// value and closes a burst when the line has been quiet for a full watchdog period.
module q_measure
    import q_loop_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = BUS_WIDTH_DEF,
    parameter int unsigned WTD_BUS_WIDTH = WTD_BUS_WIDTH_DEF,
    parameter int unsigned Q_PER_PULSE   = Q_PER_PULSE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_active,
    input  logic                 i_q_serialized,
    output logic [BUS_WIDTH-1:0] o_q_measured,
    output logic                 o_ready
);

    localparam int unsigned ACC_MAX = (1 << BUS_WIDTH) - 1;
    localparam logic [WTD_BUS_WIDTH-1:0] WDT_MAX = '1;

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_sync3;
    logic [BUS_WIDTH-1:0]     r_acc;
    logic [WTD_BUS_WIDTH-1:0] r_wdt;
    logic [BUS_WIDTH-1:0]     r_q_meas;
    logic                     r_ready;

    logic                     w_pulse;
    logic                     w_expire;
    logic [BUS_WIDTH-1:0]     w_acc_inc;
    logic [BUS_WIDTH-1:0]     w_acc_nxt;
    logic [WTD_BUS_WIDTH-1:0] w_wdt_nxt;
    logic [BUS_WIDTH-1:0]     w_q_meas_nxt;
    logic                     w_ready_nxt;

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_q_serialized;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_pulse   = r_sync2 & ~r_sync3;
    assign w_expire  = (r_wdt == WDT_MAX) && (r_acc != '0);
    assign w_acc_inc = BUS_WIDTH'(sat_add(int'(r_acc), int'(Q_PER_PULSE), int'(ACC_MAX)));

    always_comb begin
        w_acc_nxt    = r_acc;
        w_wdt_nxt    = r_wdt;
        w_q_meas_nxt = r_q_meas;
        w_ready_nxt  = 1'b0;
        if (!i_active) begin
            w_acc_nxt = '0;
            w_wdt_nxt = '0;
        end else if (w_expire) begin
            // A pulse coinciding with expiry opens the next burst.
            w_q_meas_nxt = r_acc;
            w_ready_nxt  = 1'b1;
            w_acc_nxt    = w_pulse ? BUS_WIDTH'(Q_PER_PULSE) : '0;
            w_wdt_nxt    = '0;
        end else begin
            if (w_pulse) begin
                w_acc_nxt = w_acc_inc;
            end
            if (r_sync2) begin
                w_wdt_nxt = '0;
            end else if (r_wdt != WDT_MAX) begin
                w_wdt_nxt = r_wdt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_wdt    <= '0;
            r_q_meas <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_acc    <= w_acc_nxt;
            r_wdt    <= w_wdt_nxt;
            r_q_meas <= w_q_meas_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign o_q_measured = r_q_meas;
    assign o_ready      = r_ready;

endmodule

// File: rtl/q_loop_controller.sv
// Closed-loop Q regulator: steps the current reference by the Q error after each measurement,
// with an optional guard that backs the current off when Q collapses between measurements.
module q_loop_controller
    import q_loop_pkg::*;
#(
    parameter int unsigned BUS_WIDTH         = BUS_WIDTH_DEF,
    parameter int unsigned WTD_BUS_WIDTH     = WTD_BUS_WIDTH_DEF,
    parameter int unsigned Q_PER_PULSE       = Q_PER_PULSE_DEF,
    parameter int unsigned TOL               = TOL_DEF,
    parameter int unsigned I_REF_DELTA_INSTB = I_REF_DELTA_INSTB_DEF,
    parameter int unsigned DELTA_Q_INSTB     = DELTA_Q_INSTB_DEF,
    parameter int unsigned INCLUDE_Q_DROP    = INCLUDE_Q_DROP_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 q_serialized,
    input  logic [BUS_WIDTH-1:0] q_desired,
    output logic [BUS_WIDTH-1:0] i_ref_out,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 converged
);

    localparam int unsigned I_MAX = (1 << BUS_WIDTH) - 1;

    logic                   w_active;
    logic [BUS_WIDTH-1:0]   w_q_meas;
    logic                   w_ready;
    logic signed [BUS_WIDTH:0] w_err;
    int                     w_err_abs;
    int                     w_drop;
    logic                   w_instab;
    logic                   w_in_tol;

    logic [BUS_WIDTH-1:0]   r_i_ref;
    logic                   r_conv;
    logic [BUS_WIDTH-1:0]   r_prev_q;
    logic [BUS_WIDTH-1:0]   w_i_ref_nxt;
    logic                   w_conv_nxt;
    logic [BUS_WIDTH-1:0]   w_prev_q_nxt;

    assign w_active = enable & start;

    q_measure #(
        .BUS_WIDTH     (BUS_WIDTH),
        .WTD_BUS_WIDTH (WTD_BUS_WIDTH),
        .Q_PER_PULSE   (Q_PER_PULSE)
    ) u_q_measure (
        .clk            (clk),
        .rst            (rst),
        .i_active       (w_active),
        .i_q_serialized (q_serialized),
        .o_q_measured   (w_q_meas),
        .o_ready        (w_ready)
    );

    assign w_err     = $signed({1'b0, q_desired}) - $signed({1'b0, w_q_meas});
    assign w_err_abs = (w_err < 0) ? -int'(w_err) : int'(w_err);
    assign w_in_tol  = (w_err_abs <= int'(TOL));
    // Positive drop means Q fell since the previous measurement.
    assign w_drop    = int'(r_prev_q) - int'(w_q_meas);
    assign w_instab  = (INCLUDE_Q_DROP != 0) && (w_drop > int'(DELTA_Q_INSTB));

    always_comb begin
        w_i_ref_nxt  = r_i_ref;
        w_conv_nxt   = r_conv;
        w_prev_q_nxt = r_prev_q;
        if (!w_active) begin
            w_conv_nxt = 1'b0;
        end else if (w_ready) begin
            w_prev_q_nxt = w_q_meas;
            if (w_instab) begin
                w_i_ref_nxt = BUS_WIDTH'(sat_sub(int'(r_i_ref), int'(I_REF_DELTA_INSTB),
                                                 int'(I_MAX)));
                w_conv_nxt  = 1'b0;
            end else if (w_in_tol) begin
                w_conv_nxt = 1'b1;
            end else begin
                w_i_ref_nxt = BUS_WIDTH'(sat_add(int'(r_i_ref), int'(w_err), int'(I_MAX)));
                w_conv_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_ref  <= '0;
            r_conv   <= 1'b0;
            r_prev_q <= '0;
        end else begin
            r_i_ref  <= w_i_ref_nxt;
            r_conv   <= w_conv_nxt;
            r_prev_q <= w_prev_q_nxt;
        end
    end

    assign i_ref_out  = r_i_ref;
    assign converged  = r_conv;
    assign q_measured = w_q_meas;
    assign ready      = w_ready;

endmodule

// File: tb/tb_q_loop_controller.sv
// Scoreboard bench for q_loop_controller: one instance with the instability guard, one without,
// both driven by the same pulse bursts and checked against a burst-level reference model.
module tb_q_loop_controller;

    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic          q_ser = 1'b0;
    logic [BW-1:0] q_desired = '0;

    logic [BW-1:0] iref_a, qm_a, iref_b, qm_b;
    logic          rdy_a, conv_a, rdy_b, conv_b;

    always #5 clk = ~clk;

    q_loop_controller u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .start        (start),
        .q_serialized (q_ser),
        .q_desired    (q_desired),
        .i_ref_out    (iref_a),
        .q_measured   (qm_a),
        .ready        (rdy_a),
        .converged    (conv_a)
    );

    q_loop_controller #(
        .INCLUDE_Q_DROP (0)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .start        (start),
        .q_serialized (q_ser),
        .q_desired    (q_desired),
        .i_ref_out    (iref_b),
        .q_measured   (qm_b),
        .ready        (rdy_b),
        .converged    (conv_b)
    );

    typedef struct {
        int q_meas;
        int iref_a;
        int conv_a;
        int iref_b;
        int conv_b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state, advanced once per burst.
    int m_iref_a = 0;
    int m_iref_b = 0;
    int m_conv_a = 0;
    int m_conv_b = 0;
    int m_prev   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ctrl_step(input int iref, input int err, input bit instab,
                                     output int conv);
        int r;
        if (instab) begin
            conv = 0;
            r = (iref > 10) ? iref - 10 : 0;
        end else if (err <= 6 && err >= -6) begin
            conv = 1;
            r = iref;
        end else begin
            conv = 0;
            r = iref + err;
            if (r < 0) r = 0;
            if (r > 1023) r = 1023;
        end
        return r;
    endfunction

    task automatic send_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) q_ser = 1'b1;
            @(negedge clk);
            @(negedge clk) q_ser = 1'b0;
            @(negedge clk);
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic send_burst(input int n, input int qd);
        exp_t e;
        int   meas;
        bit   instab;
        @(negedge clk) q_desired = BW'(qd);
        meas     = (n * 3 > 1023) ? 1023 : n * 3;
        instab   = (m_prev - meas) > 50;
        m_iref_a = ctrl_step(m_iref_a, qd - meas, instab, m_conv_a);
        m_iref_b = ctrl_step(m_iref_b, qd - meas, 1'b0, m_conv_b);
        m_prev   = meas;
        e.q_meas = meas;
        e.iref_a = m_iref_a;
        e.conv_a = m_conv_a;
        e.iref_b = m_iref_b;
        e.conv_b = m_conv_b;
        sb.push_back(e);
        send_pulses(n);
    endtask

    // Monitor: every ready strobe pops one expectation, then checks the control update.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_a || rdy_b) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", int'(rdy_a | rdy_b), 0);
                end else begin
                    e = sb.pop_front();
                    check("ready_a", int'(rdy_a), 1);
                    check("ready_b", int'(rdy_b), 1);
                    check("q_measured_a", int'(qm_a), e.q_meas);
                    check("q_measured_b", int'(qm_b), e.q_meas);
                    @(posedge clk);
                    #1;
                    check("ready_strobe_a", int'(rdy_a), 0);
                    check("i_ref_a", int'(iref_a), e.iref_a);
                    check("converged_a", int'(conv_a), e.conv_a);
                    check("i_ref_b", int'(iref_b), e.iref_b);
                    check("converged_b", int'(conv_b), e.conv_b);
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int dn[9] = '{5, 12, 10, 40, 20, 400, 1, 100, 50};
        int dq[9] = '{40, 40, 40, 200, 200, 1023, 1023, 0, 0};
        int n;
        int qd;
        int wait_cyc;

        repeat (3) @(negedge clk);
        check("reset_i_ref_a", int'(iref_a), 0);
        check("reset_q_meas_a", int'(qm_a), 0);
        check("reset_ready_a", int'(rdy_a), 0);
        check("reset_conv_a", int'(conv_a), 0);
        check("reset_i_ref_b", int'(iref_b), 0);
        check("reset_conv_b", int'(conv_b), 0);
        rst = 1'b1;

        // Idle: enabled but no start, pulses must not produce ready.
        @(negedge clk) enable = 1'b1;
        send_pulses(6);
        check("idle_i_ref_a", int'(iref_a), 0);
        check("idle_q_meas_a", int'(qm_a), 0);

        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_burst(dn[i], dq[i]);
        end

        for (int i = 0; i < 20; i++) begin
            n = int'($urandom_range(1, 60));
            if ($urandom_range(0, 1) == 1) begin
                qd = n * 3 + int'($urandom_range(0, 14)) - 7;
                if (qd < 0) qd = 0;
            end else begin
                qd = int'($urandom_range(0, 1023));
            end
            send_burst(n, qd);
        end

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("scoreboard_drain", sb.size(), 0);

        // Dropping start clears converged and holds the current reference.
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1;
        check("stop_conv_a", int'(conv_a), 0);
        check("stop_conv_b", int'(conv_b), 0);
        check("stop_i_ref_a", int'(iref_a), m_iref_a);
        check("stop_i_ref_b", int'(iref_b), m_iref_b);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
